link_tx: RTL and testbench

LINK_TX -- requirements
Module: link_tx

---
 rtl/link_tx.sv | 161 ++++++++++++++++
 tb/tb_link_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/link_tx.sv
// ============================================================================
// Module  : link_tx
// Brief   : Flit transmit stage: small FIFO, on/off flow control toward the
//           downstream circular buffer, packet framing checker and an
//           optional sent-flit counter (enabled by LINK_TX_STATS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package link_tx_pkg;
  localparam int unsigned FLIT_DATA_W = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t              flit_label;
    logic [FLIT_DATA_W-1:0]   data;
  } flit_Data_noVC;
endpackage

module link_tx
  import link_tx_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  flit_Data_noVC in_flit,
  input  logic          in_valid,
  output logic          in_ready,
  output flit_Data_noVC out_flit,
  output logic          out_write,
  input  logic          on_off_i,
  output logic          proto_err,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int unsigned c_AW     = $clog2(TX_DEPTH);
  localparam logic [0:0]  c_IDLE   = 1'b0;
  localparam logic [0:0]  c_ACTIVE = 1'b1;

  flit_Data_noVC   r_mem [TX_DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [c_AW:0]   w_wr_ptr_nxt;
  logic [c_AW:0]   w_rd_ptr_nxt;
  logic            w_empty;
  logic            w_full_nxt;
  logic            w_push;
  logic            w_pop;
  flit_Data_noVC   w_head;

  logic            r_in_ready;
  logic            r_out_write;
  flit_Data_noVC   r_out_flit;
  logic            r_proto_err;
  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic            w_frame_err;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_push       = in_valid & r_in_ready;
  assign w_pop        = ~w_empty & on_off_i;
  assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
  assign w_head       = r_mem[r_rd_ptr[c_AW-1:0]];

  // Ready is a register of the post-edge occupancy, so it never sees on_off_i combinationally
  assign w_full_nxt = (w_wr_ptr_nxt[c_AW] != w_rd_ptr_nxt[c_AW]) &&
                      (w_wr_ptr_nxt[c_AW-1:0] == w_rd_ptr_nxt[c_AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= in_flit;
    end
  end

  // Framing violations are flagged but the flit still follows its own label
  always_comb begin
    w_state_nxt = r_state;
    w_frame_err = 1'b0;
    if (w_pop) begin
      case (w_head.flit_label)
        HEAD: begin
          w_frame_err = (r_state == c_ACTIVE);
          w_state_nxt = c_ACTIVE;
        end
        BODY: begin
          w_frame_err = (r_state == c_IDLE);
        end
        TAIL: begin
          w_frame_err = (r_state == c_IDLE);
          w_state_nxt = c_IDLE;
        end
        HEADTAIL: begin
          w_frame_err = (r_state == c_ACTIVE);
          w_state_nxt = c_IDLE;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b0;
      r_out_write <= 1'b0;
      r_out_flit  <= '0;
      r_proto_err <= 1'b0;
      r_state     <= c_IDLE;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_in_ready  <= ~w_full_nxt;
      r_out_write <= w_pop;
      r_state     <= w_state_nxt;
      if (w_pop) begin
        r_out_flit <= w_head;
      end
      if (w_frame_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_write = r_out_write;
  assign out_flit  = r_out_flit;
  assign proto_err = r_proto_err;

`ifdef LINK_TX_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] r_sent_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sent_cnt <= '0;
    end else if (r_out_write) begin
      r_sent_cnt <= r_sent_cnt + c_CNT_ONE;
    end
  end

  assign sent_cnt = r_sent_cnt;
`else
  assign sent_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_link_tx.sv
// ============================================================================
// Module  : tb_link_tx
// Brief   : Directed self-checking bench for link_tx (TX_DEPTH=4, CNT_W=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_link_tx;
  import link_tx_pkg::*;

  localparam int unsigned TX_DEPTH = 4;
  localparam int unsigned CNT_W    = 4;
`ifdef LINK_TX_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  flit_Data_noVC    in_flit;
  logic             in_valid;
  logic             in_ready;
  flit_Data_noVC    out_flit;
  logic             out_write;
  logic             on_off_i;
  logic             proto_err;
  logic [CNT_W-1:0] sent_cnt;

  int n_chk = 0;
  int n_err = 0;

  link_tx #(.TX_DEPTH(TX_DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_write (out_write),
    .on_off_i  (on_off_i),
    .proto_err (proto_err),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic flit_Data_noVC mk(input flit_label_t l, input logic [31:0] d);
    return '{flit_label: l, data: d};
  endfunction

  flit_Data_noVC s [4];
  flit_Data_noVC b [5];
  flit_Data_noVC m [3];
  flit_Data_noVC f0, f1, g;

  initial begin
    s[0] = mk(HEAD, 32'hA000_0000); s[1] = mk(BODY, 32'hA000_0001);
    s[2] = mk(BODY, 32'hA000_0002); s[3] = mk(TAIL, 32'hA000_0003);
    b[0] = mk(HEAD, 32'hB000_0000); b[1] = mk(BODY, 32'hB000_0001);
    b[2] = mk(BODY, 32'hB000_0002); b[3] = mk(TAIL, 32'hB000_0003);
    b[4] = mk(HEAD, 32'hB000_0004);
    m[0] = mk(HEAD, 32'hC000_0000); m[1] = mk(BODY, 32'hC000_0001);
    m[2] = mk(TAIL, 32'hC000_0002);
    f0   = mk(BODY, 32'hD000_0000); f1 = mk(HEADTAIL, 32'hD000_0001);
    g    = mk(HEADTAIL, 32'hE000_0000);

    rst_n = 1'b0; on_off_i = 1'b1; in_valid = 1'b0; in_flit = '0;
    tick(); tick();
    chk("rst_ready", 64'(in_ready), 64'(0));
    chk("rst_write", 64'(out_write), 64'(0));
    chk("rst_flit", 64'(out_flit), 64'(0));
    chk("rst_perr", 64'(proto_err), 64'(0));
    chk("rst_cnt", 64'(sent_cnt), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'(1));
    chk("post_rst_write", 64'(out_write), 64'(0));

    // Streaming: first flit appears two cycles after its push
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_flit = s[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("stream_write", 64'(out_write), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("stream_flit", 64'(out_flit), 64'(s[c-1]));
    end
    chk("stream_perr", 64'(proto_err), 64'(0));
    chk("stream_ready", 64'(in_ready), 64'(1));

    // Backpressure: four accepted, fifth refused
    on_off_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 64'(in_ready), 64'(i < 4));
      in_valid = 1'b1; in_flit = b[i];
      tick();
      chk("bp_write", 64'(out_write), 64'(0));
    end
    in_valid = 1'b0;
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    on_off_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_drain_write", 64'(out_write), 64'(k < 4));
      if (k < 4) chk("bp_drain_flit", 64'(out_flit), 64'(b[k]));
    end
    chk("bp_ready_again", 64'(in_ready), 64'(1));

    // Mid-packet stall
    in_valid = 1'b1; in_flit = m[0];
    tick();
    chk("stall_w0", 64'(out_write), 64'(0));
    in_flit = m[1];
    tick();
    chk("stall_head_write", 64'(out_write), 64'(1));
    chk("stall_head_flit", 64'(out_flit), 64'(m[0]));
    on_off_i = 1'b0; in_flit = m[2];
    tick();
    in_valid = 1'b0;
    chk("stall_off_write", 64'(out_write), 64'(0));
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_off_write", 64'(out_write), 64'(0));
      chk("stall_hold_flit", 64'(out_flit), 64'(m[0]));
    end
    on_off_i = 1'b1;
    tick();
    chk("stall_body_write", 64'(out_write), 64'(1));
    chk("stall_body_flit", 64'(out_flit), 64'(m[1]));
    tick();
    chk("stall_tail_write", 64'(out_write), 64'(1));
    chk("stall_tail_flit", 64'(out_flit), 64'(m[2]));
    tick();
    chk("stall_idle_write", 64'(out_write), 64'(0));
    chk("stall_idle_flit", 64'(out_flit), 64'(m[2]));
    chk("stall_perr", 64'(proto_err), 64'(0));

    // Framing error: BODY while idle
    in_valid = 1'b1; in_flit = f0;
    tick();
    in_valid = 1'b0;
    chk("err_pre_perr", 64'(proto_err), 64'(0));
    tick();
    chk("err_write", 64'(out_write), 64'(1));
    chk("err_flit", 64'(out_flit), 64'(f0));
    chk("err_perr", 64'(proto_err), 64'(1));
    in_valid = 1'b1; in_flit = f1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("err_ht_write", 64'(out_write), 64'(1));
    chk("err_ht_flit", 64'(out_flit), 64'(f1));
    tick();
    chk("err_sticky", 64'(proto_err), 64'(1));
    chk("cnt_13", 64'(sent_cnt), 64'(c_STATS ? 13 : 0));

    // Four more flits: 17 total wraps a 4-bit counter to 1
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_flit = mk(HEADTAIL, 32'hF000_0000 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("cnt_wrap", 64'(sent_cnt), 64'(c_STATS ? 1 : 0));
    chk("wrap_perr", 64'(proto_err), 64'(1));

    // Reset with three flits queued
    on_off_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_flit = b[i];
      tick();
    end
    in_valid = 1'b0; rst_n = 1'b0; on_off_i = 1'b1;
    tick();
    chk("mrst_ready", 64'(in_ready), 64'(0));
    chk("mrst_write", 64'(out_write), 64'(0));
    chk("mrst_flit", 64'(out_flit), 64'(0));
    chk("mrst_perr", 64'(proto_err), 64'(0));
    chk("mrst_cnt", 64'(sent_cnt), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("mrst_ready_after", 64'(in_ready), 64'(1));
    chk("mrst_no_pulse", 64'(out_write), 64'(0));
    tick();
    chk("mrst_no_stale", 64'(out_write), 64'(0));
    in_valid = 1'b1; in_flit = g;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mrst_ht_write", 64'(out_write), 64'(1));
    chk("mrst_ht_flit", 64'(out_flit), 64'(g));
    chk("mrst_ht_perr", 64'(proto_err), 64'(0));
    tick();
    chk("mrst_cnt_one", 64'(sent_cnt), 64'(c_STATS ? 1 : 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
